id_ex_stage: RTL and testbench

//  Decode-to-execute pipeline register for the 32-register MIPS core. It sits directly

---
 rtl/pipe_pkg.sv | 32 +++
 rtl/id_ex_stage_fwd_mux.sv | 45 ++++
 rtl/id_ex_stage.sv | 116 +++++++++++
 tb/tb_id_ex_stage.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline types for the MIPS core: widths, control-bundle
// bit map, forward-select encoding and the ID/EX register bundle.
package pipe_pkg;

    localparam int XLEN    = 32;
    localparam int RADDR_W = 5;
    localparam int CTRL_W  = 8;

    localparam int CTRL_REG_WRITE  = 7;
    localparam int CTRL_MEM_READ   = 6;
    localparam int CTRL_MEM_WRITE  = 5;
    localparam int CTRL_ALU_SRC    = 4;
    localparam int CTRL_ALU_OP_MSB = 3;
    localparam int CTRL_ALU_OP_LSB = 0;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_WB  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_EX  = 2'd3
    } fwd_sel_e;

    typedef struct packed {
        logic               valid;
        logic [XLEN-1:0]    rs_val;
        logic [XLEN-1:0]    rt_val;
        logic [XLEN-1:0]    imm;
        logic [RADDR_W-1:0] dst;
        logic [CTRL_W-1:0]  ctrl;
    } id_ex_t;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forward select for one source register: EX > MEM > WB > regfile.
// Ports: src, ex/mem/wb producer tags and data, rf_data in; val out.
module fwd_mux
    import pipe_pkg::*;
(
    input  logic [RADDR_W-1:0] src,
    input  logic [XLEN-1:0]    rf_data,
    input  logic               ex_fwd,
    input  logic [RADDR_W-1:0] ex_dst,
    input  logic [XLEN-1:0]    ex_alu_result,
    input  logic               mem_reg_write,
    input  logic [RADDR_W-1:0] mem_dst,
    input  logic [XLEN-1:0]    mem_fwd_data,
    input  logic               wb_reg_write,
    input  logic [RADDR_W-1:0] wb_dst,
    input  logic [XLEN-1:0]    wb_data,
    output logic [XLEN-1:0]    val
);

    fwd_sel_e sel;

    always_comb begin
        sel = FWD_RF;
        if (ex_fwd && ex_dst == src)
            sel = FWD_EX;
        else if (mem_reg_write && mem_dst == src)
            sel = FWD_MEM;
        else if (wb_reg_write && wb_dst == src)
            sel = FWD_WB;
    end

    // r0 reads as zero no matter which producer claims it
    always_comb begin
        val = '0;
        if (src != '0) begin
            unique case (sel)
                FWD_EX:  val = ex_alu_result;
                FWD_MEM: val = mem_fwd_data;
                FWD_WB:  val = wb_data;
                FWD_RF:  val = rf_data;
            endcase
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use stall.
// Ports: ID operands/controls, EX/MEM/WB forward taps, flush/hold in;
// stall and registered ex_* bundle out.
module id_ex_stage
    import pipe_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_valid,
    input  logic [RADDR_W-1:0] id_rs,
    input  logic [RADDR_W-1:0] id_rt,
    input  logic               id_use_rs,
    input  logic               id_use_rt,
    input  logic [RADDR_W-1:0] id_dst,
    input  logic [XLEN-1:0]    id_rs_data,
    input  logic [XLEN-1:0]    id_rt_data,
    input  logic [XLEN-1:0]    id_imm,
    input  logic [CTRL_W-1:0]  id_ctrl,
    input  logic [XLEN-1:0]    ex_alu_result,
    input  logic               mem_reg_write,
    input  logic [RADDR_W-1:0] mem_dst,
    input  logic [XLEN-1:0]    mem_fwd_data,
    input  logic               wb_reg_write,
    input  logic [RADDR_W-1:0] wb_dst,
    input  logic [XLEN-1:0]    wb_data,
    input  logic               flush,
    input  logic               hold,
    output logic               stall,
    output logic               ex_valid,
    output logic [XLEN-1:0]    ex_rs_val,
    output logic [XLEN-1:0]    ex_rt_val,
    output logic [XLEN-1:0]    ex_imm,
    output logic [RADDR_W-1:0] ex_dst,
    output logic [CTRL_W-1:0]  ex_ctrl
);

    id_ex_t q;
    id_ex_t d;

    logic            ex_fwd;
    logic            lu;
    logic [XLEN-1:0] rs_fwd;
    logic [XLEN-1:0] rt_fwd;

    // A load's result is not ready in EX, and a bubble has ctrl=0,
    // so neither can act as an EX forwarding source.
    assign ex_fwd = q.valid
                  & q.ctrl[CTRL_REG_WRITE]
                  & ~q.ctrl[CTRL_MEM_READ];

    assign lu = id_valid & q.valid
              & q.ctrl[CTRL_MEM_READ]
              & (q.dst != '0)
              & ((id_use_rs & (q.dst == id_rs))
               | (id_use_rt & (q.dst == id_rt)));

    assign stall = (lu & ~flush) | hold;

    fwd_mux u_fwd_rs (
        .src           (id_rs),
        .rf_data       (id_rs_data),
        .ex_fwd        (ex_fwd),
        .ex_dst        (q.dst),
        .ex_alu_result (ex_alu_result),
        .mem_reg_write (mem_reg_write),
        .mem_dst       (mem_dst),
        .mem_fwd_data  (mem_fwd_data),
        .wb_reg_write  (wb_reg_write),
        .wb_dst        (wb_dst),
        .wb_data       (wb_data),
        .val           (rs_fwd)
    );

    fwd_mux u_fwd_rt (
        .src           (id_rt),
        .rf_data       (id_rt_data),
        .ex_fwd        (ex_fwd),
        .ex_dst        (q.dst),
        .ex_alu_result (ex_alu_result),
        .mem_reg_write (mem_reg_write),
        .mem_dst       (mem_dst),
        .mem_fwd_data  (mem_fwd_data),
        .wb_reg_write  (wb_reg_write),
        .wb_dst        (wb_dst),
        .wb_data       (wb_data),
        .val           (rt_fwd)
    );

    always_comb begin
        d        = '0;
        d.valid  = id_valid;
        d.rs_val = rs_fwd;
        d.rt_val = rt_fwd;
        d.imm    = id_imm;
        d.dst    = id_dst;
        d.ctrl   = id_valid ? id_ctrl : '0;
    end

    // flush > hold > load-use bubble > normal load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else if (flush)
            q <= '0;
        else if (!hold)
            q <= lu ? '0 : d;
    end

    assign ex_valid  = q.valid;
    assign ex_rs_val = q.rs_val;
    assign ex_rt_val = q.rt_val;
    assign ex_imm    = q.imm;
    assign ex_dst    = q.dst;
    assign ex_ctrl   = q.ctrl;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_dst;
    logic        id_use_rs, id_use_rt;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [7:0]  id_ctrl;
    logic [31:0] ex_alu_result;
    logic        mem_reg_write;
    logic [4:0]  mem_dst;
    logic [31:0] mem_fwd_data;
    logic        wb_reg_write;
    logic [4:0]  wb_dst;
    logic [31:0] wb_data;
    logic        flush, hold;
    logic        stall, ex_valid;
    logic [31:0] ex_rs_val, ex_rt_val, ex_imm;
    logic [4:0]  ex_dst;
    logic [7:0]  ex_ctrl;

    int total = 0;
    int bad   = 0;

    localparam logic [7:0] C_ADD = 8'h82;
    localparam logic [7:0] C_LW  = 8'hD0;
    localparam logic [7:0] C_SW  = 8'h30;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_dst(id_dst), .id_rs_data(id_rs_data),
        .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_ctrl(id_ctrl), .ex_alu_result(ex_alu_result),
        .mem_reg_write(mem_reg_write), .mem_dst(mem_dst),
        .mem_fwd_data(mem_fwd_data),
        .wb_reg_write(wb_reg_write), .wb_dst(wb_dst),
        .wb_data(wb_data), .flush(flush), .hold(hold),
        .stall(stall), .ex_valid(ex_valid),
        .ex_rs_val(ex_rs_val), .ex_rt_val(ex_rt_val),
        .ex_imm(ex_imm), .ex_dst(ex_dst), .ex_ctrl(ex_ctrl)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        id_valid = 0; id_rs = 0; id_rt = 0; id_dst = 0;
        id_use_rs = 0; id_use_rt = 0;
        id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_ctrl = 0;
        ex_alu_result = 0;
        mem_reg_write = 0; mem_dst = 0; mem_fwd_data = 0;
        wb_reg_write = 0; wb_dst = 0; wb_data = 0;
        flush = 0; hold = 0;
    endtask

    task automatic set_id(input logic [4:0] rs, input logic [4:0] rt,
                          input logic urs, input logic urt,
                          input logic [4:0] dst,
                          input logic [31:0] rsd, input logic [31:0] rtd,
                          input logic [31:0] imm, input logic [7:0] ctrl);
        id_valid = 1; id_rs = rs; id_rt = rt;
        id_use_rs = urs; id_use_rt = urt; id_dst = dst;
        id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_ctrl = ctrl;
    endtask

    task automatic test_reset();
        rst_n = 0;
        clear_in();
        tick(); tick();
        total++;
        if ({ex_valid, ex_ctrl, ex_dst, stall} !== 15'd0 ||
            ex_rs_val !== 0 || ex_rt_val !== 0 || ex_imm !== 0) begin
            bad++;
            $display("FAIL reset_state valid=%0b ctrl=%h rs=%h rt=%h imm=%h dst=%0d stall=%0b want all 0",
                     ex_valid, ex_ctrl, ex_rs_val, ex_rt_val, ex_imm, ex_dst, stall);
        end
        rst_n = 1;
        set_id(5'd1, 5'd2, 1, 1, 5'd2, 32'h11, 32'h22, 32'h5, C_ADD);
        tick();
        total++;
        if (ex_valid !== 1 || ex_rs_val !== 32'h11 || ex_rt_val !== 32'h22 ||
            ex_imm !== 32'h5 || ex_dst !== 5'd2 || ex_ctrl !== C_ADD) begin
            bad++;
            $display("FAIL first_capture valid=%0b rs=%h rt=%h imm=%h dst=%0d ctrl=%h want 1 11 22 5 2 82",
                     ex_valid, ex_rs_val, ex_rt_val, ex_imm, ex_dst, ex_ctrl);
        end
        set_id(5'd1, 5'd0, 1, 0, 5'd4, 32'h100, 32'h0, 32'h8, C_LW);
        tick();
        set_id(5'd4, 5'd1, 1, 1, 5'd6, 32'hAAAA, 32'h11, 32'h0, C_ADD);
        #1;
        total++;
        if (stall !== 1'b1) begin
            bad++;
            $display("FAIL reset_pre_stall stall=%0b want 1", stall);
        end
        #2 rst_n = 0;
        #1;
        total++;
        if (ex_valid !== 0 || ex_ctrl !== 0 || ex_dst !== 0 ||
            ex_imm !== 0 || ex_rs_val !== 0 || stall !== 0) begin
            bad++;
            $display("FAIL async_reset valid=%0b ctrl=%h dst=%0d imm=%h rs=%h stall=%0b want all 0",
                     ex_valid, ex_ctrl, ex_dst, ex_imm, ex_rs_val, stall);
        end
        tick();
        rst_n = 1;
        clear_in();
        tick();
    endtask

    task automatic test_ex_fwd();
        clear_in();
        set_id(5'd1, 5'd2, 1, 1, 5'd3, 32'h1, 32'h2, 32'h0, C_ADD);
        tick();
        set_id(5'd3, 5'd0, 1, 0, 5'd8, 32'hDEAD, 32'h0, 32'h0, C_ADD);
        ex_alu_result = 32'h10;
        tick();
        total++;
        if (ex_rs_val !== 32'h10) begin
            bad++;
            $display("FAIL ex_forward rs=%h want 10", ex_rs_val);
        end
    endtask

    task automatic test_priority();
        clear_in();
        mem_reg_write = 1; mem_dst = 5'd5; mem_fwd_data = 32'h22;
        wb_reg_write = 1;  wb_dst = 5'd5;  wb_data = 32'h33;
        set_id(5'd5, 5'd5, 1, 1, 5'd9, 32'h1, 32'h2, 32'h0, C_ADD);
        tick();
        total++;
        if (ex_rs_val !== 32'h22 || ex_rt_val !== 32'h22) begin
            bad++;
            $display("FAIL mem_over_wb rs=%h rt=%h want 22 22", ex_rs_val, ex_rt_val);
        end
        mem_reg_write = 0;
        tick();
        total++;
        if (ex_rs_val !== 32'h33) begin
            bad++;
            $display("FAIL wb_forward rs=%h want 33", ex_rs_val);
        end
        mem_reg_write = 1; mem_dst = 5'd0; mem_fwd_data = 32'h66;
        wb_dst = 5'd0; wb_data = 32'h55;
        set_id(5'd0, 5'd0, 1, 1, 5'd9, 32'h77, 32'h78, 32'h0, C_ADD);
        tick();
        total++;
        if (ex_rs_val !== 0 || ex_rt_val !== 0) begin
            bad++;
            $display("FAIL r0_zero rs=%h rt=%h want 0 0", ex_rs_val, ex_rt_val);
        end
        clear_in();
        set_id(5'd1, 5'd2, 1, 1, 5'd10, 32'h0, 32'h0, 32'h4, C_SW);
        tick();
        ex_alu_result = 32'hBAD;
        set_id(5'd10, 5'd0, 1, 0, 5'd11, 32'h1234, 32'h0, 32'h0, C_ADD);
        tick();
        total++;
        if (ex_rs_val !== 32'h1234) begin
            bad++;
            $display("FAIL no_fwd_without_regwrite rs=%h want 1234", ex_rs_val);
        end
    endtask

    task automatic test_load_use();
        clear_in();
        set_id(5'd1, 5'd0, 1, 0, 5'd4, 32'h100, 32'h0, 32'h8, C_LW);
        tick();
        ex_alu_result = 32'h1000;
        set_id(5'd4, 5'd1, 1, 1, 5'd6, 32'hAAAA, 32'h11, 32'h0, C_ADD);
        #1;
        total++;
        if (stall !== 1'b1) begin
            bad++;
            $display("FAIL lu_stall stall=%0b want 1", stall);
        end
        tick();
        total++;
        if (ex_valid !== 0 || ex_ctrl !== 0) begin
            bad++;
            $display("FAIL lu_bubble valid=%0b ctrl=%h want 0 00", ex_valid, ex_ctrl);
        end
        mem_reg_write = 1; mem_dst = 5'd4; mem_fwd_data = 32'h4444;
        #1;
        total++;
        if (stall !== 1'b0) begin
            bad++;
            $display("FAIL lu_single_bubble stall=%0b want 0", stall);
        end
        tick();
        total++;
        if (ex_valid !== 1 || ex_rs_val !== 32'h4444 ||
            ex_rt_val !== 32'h11 || ex_dst !== 5'd6) begin
            bad++;
            $display("FAIL lu_retry valid=%0b rs=%h rt=%h dst=%0d want 1 4444 11 6",
                     ex_valid, ex_rs_val, ex_rt_val, ex_dst);
        end
        clear_in();
        set_id(5'd1, 5'd0, 1, 0, 5'd4, 32'h100, 32'h0, 32'h8, C_LW);
        tick();
        set_id(5'd4, 5'd3, 0, 1, 5'd6, 32'h0, 32'h3, 32'h0, C_ADD);
        #1;
        total++;
        if (stall !== 1'b0) begin
            bad++;
            $display("FAIL lu_independent stall=%0b want 0", stall);
        end
        tick();
        total++;
        if (ex_valid !== 1 || ex_dst !== 5'd6) begin
            bad++;
            $display("FAIL lu_independent_capture valid=%0b dst=%0d want 1 6", ex_valid, ex_dst);
        end
    endtask

    task automatic test_back_to_back();
        int stalls;
        clear_in();
        set_id(5'd1, 5'd0, 1, 0, 5'd4, 32'h100, 32'h0, 32'h0, C_LW);
        tick();
        set_id(5'd4, 5'd0, 1, 0, 5'd5, 32'h0, 32'h0, 32'h0, C_LW);
        stalls = 0;
        for (int i = 0; i < 2; i++) begin
            #1;
            if (stall) stalls++;
            if (i == 0) begin
                tick();
                mem_reg_write = 1; mem_dst = 5'd4; mem_fwd_data = 32'h200;
            end
        end
        total++;
        if (stalls != 1) begin
            bad++;
            $display("FAIL b2b_first_pair stalls=%0d want 1", stalls);
        end
        tick();
        total++;
        if (ex_valid !== 1 || ex_rs_val !== 32'h200 || ex_ctrl !== C_LW) begin
            bad++;
            $display("FAIL b2b_second_load valid=%0b rs=%h ctrl=%h want 1 200 d0",
                     ex_valid, ex_rs_val, ex_ctrl);
        end
        mem_reg_write = 0;
        set_id(5'd5, 5'd0, 1, 0, 5'd7, 32'h0, 32'h0, 32'h0, C_ADD);
        stalls = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (stall) stalls++;
            tick();
            if (i == 0) begin
                mem_reg_write = 1; mem_dst = 5'd5; mem_fwd_data = 32'h500;
            end
        end
        total++;
        if (stalls != 1) begin
            bad++;
            $display("FAIL b2b_second_pair stalls=%0d want 1", stalls);
        end
    endtask

    task automatic test_flush_hold();
        clear_in();
        set_id(5'd1, 5'd0, 1, 0, 5'd4, 32'h100, 32'h0, 32'h0, C_LW);
        tick();
        set_id(5'd4, 5'd0, 1, 0, 5'd6, 32'h0, 32'h0, 32'h0, C_ADD);
        flush = 1;
        #1;
        total++;
        if (stall !== 1'b0) begin
            bad++;
            $display("FAIL flush_drops_stall stall=%0b want 0", stall);
        end
        tick();
        total++;
        if (ex_valid !== 0 || ex_ctrl !== 0) begin
            bad++;
            $display("FAIL flush_kill valid=%0b ctrl=%h want 0 00", ex_valid, ex_ctrl);
        end
        clear_in();
        set_id(5'd2, 5'd0, 1, 0, 5'd12, 32'h31, 32'h0, 32'h5A, C_ADD);
        tick();
        set_id(5'd3, 5'd1, 1, 1, 5'd13, 32'h99, 32'h98, 32'h77, C_SW);
        hold = 1;
        #1;
        total++;
        if (stall !== 1'b1) begin
            bad++;
            $display("FAIL hold_stall stall=%0b want 1", stall);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (ex_valid !== 1 || ex_dst !== 5'd12 || ex_imm !== 32'h5A ||
                ex_rs_val !== 32'h31 || ex_ctrl !== C_ADD) begin
                bad++;
                $display("FAIL hold_keep cyc=%0d valid=%0b dst=%0d imm=%h rs=%h ctrl=%h want 1 12 5a 31 82",
                         i, ex_valid, ex_dst, ex_imm, ex_rs_val, ex_ctrl);
            end
        end
        hold = 0;
        tick();
        total++;
        if (ex_dst !== 5'd13 || ex_ctrl !== C_SW) begin
            bad++;
            $display("FAIL hold_release dst=%0d ctrl=%h want 13 30", ex_dst, ex_ctrl);
        end
    endtask

    task automatic test_write_through();
        clear_in();
        tick();
        wb_reg_write = 1; wb_dst = 5'd7; wb_data = 32'h77;
        set_id(5'd1, 5'd7, 1, 1, 5'd8, 32'h1, 32'h70, 32'h0, C_ADD);
        tick();
        total++;
        if (ex_rt_val !== 32'h77 || ex_rs_val !== 32'h1) begin
            bad++;
            $display("FAIL write_through rt=%h rs=%h want 77 1", ex_rt_val, ex_rs_val);
        end
        clear_in();
        tick();
        total++;
        if (ex_valid !== 0 || ex_ctrl !== 0) begin
            bad++;
            $display("FAIL idle_capture valid=%0b ctrl=%h want 0 00", ex_valid, ex_ctrl);
        end
    endtask

    initial begin
        test_reset();
        test_ex_fwd();
        test_priority();
        test_load_use();
        test_back_to_back();
        test_flush_hold();
        test_write_through();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
